// File: rtl/elevator_floor_scheduler.sv
// Single-car SCAN elevator scheduler: latches floor requests, steps the car toward them.
// Latency: a captured request is pending next edge; motion starts one cycle after that.
// Backpressure: none; a request is accepted on every clock where req_valid is high.
//
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   req_valid/floor    - request strobe and floor number (floors >= NUM_FLOORS ignored)
//   current_floor      - floor the car is at or last passed
//   target_floor       - nearest pending floor in travel direction, else current_floor
//   is_up              - registered travel direction (1 = up)
//   moving, door_open  - registered state flags
//   arrived            - one-cycle pulse on entering DOOR_OPEN
//   pending            - outstanding request bitmap, bit i = floor i
module elevator_floor_scheduler #(
  parameter int NUM_FLOORS  = 10,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [3:0]            req_floor,
  output logic [3:0]            current_floor,
  output logic [3:0]            target_floor,
  output logic                  is_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MW = $clog2(MOVE_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  state_t state;
  logic [MW-1:0] move_tmr;
  logic [DW-1:0] door_tmr;

  logic                  req_ok;
  logic                  req_here;
  logic [3:0]            step_floor;
  logic [NUM_FLOORS-1:0] above_mask;
  logic [NUM_FLOORS-1:0] below_mask;
  logic [NUM_FLOORS-1:0] req_mask;
  logic [NUM_FLOORS-1:0] here_mask;
  logic [NUM_FLOORS-1:0] step_mask;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic                  up_avail;
  logic                  dn_avail;
  logic                  ahead;
  logic                  here_pend;
  logic                  step_pend;
  logic                  move_done;
  logic                  door_done;

  assign req_ok     = req_valid && ({1'b0, req_floor} < 5'(NUM_FLOORS));
  assign req_here   = req_ok && (req_floor == current_floor);
  // Only used when a floor exists ahead, so it never leaves 0..NUM_FLOORS-1.
  assign step_floor = is_up ? current_floor + 4'd1 : current_floor - 4'd1;

  // Per-floor decode masks keep all floor comparisons in 4-bit arithmetic.
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    req_mask   = '0;
    here_mask  = '0;
    step_mask  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (4'(i) > current_floor);
      below_mask[i] = (4'(i) < current_floor);
      req_mask[i]   = req_ok && (req_floor == 4'(i));
      here_mask[i]  = (current_floor == 4'(i));
      step_mask[i]  = (step_floor == 4'(i));
    end
  end

  assign up_avail  = |(pending & above_mask);
  assign dn_avail  = |(pending & below_mask);
  assign ahead     = is_up ? up_avail : dn_avail;
  assign here_pend = |(pending & here_mask);
  assign step_pend = |(pending & step_mask);
  assign move_done = (move_tmr == MW'(MOVE_CYCLES - 1));
  assign door_done = (door_tmr == DW'(DOOR_CYCLES - 1));

  // Nearest pending floor strictly ahead in the travel direction.
  always_comb begin
    target_floor = current_floor;
    if (is_up) begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (pending[i] && above_mask[i]) target_floor = 4'(i);
      end
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i] && below_mask[i]) target_floor = 4'(i);
      end
    end
  end

  // Set is applied before clear, so a request for the floor being served this
  // cycle is absorbed by that stop instead of leaving a second stop behind.
  always_comb begin
    set_mask = req_mask;
    clr_mask = '0;
    case (state)
      IDLE:      if (req_here || here_pend) clr_mask = here_mask;
      MOVING:    if (move_done && ahead && step_pend) clr_mask = step_mask;
      DOOR_OPEN: if (req_here) set_mask = '0;
      default:   clr_mask = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      current_floor <= '0;
      is_up         <= 1'b0;
      moving        <= 1'b0;
      door_open     <= 1'b0;
      arrived       <= 1'b0;
      pending       <= '0;
      move_tmr      <= '0;
      door_tmr      <= '0;
    end else begin
      pending <= (pending | set_mask) & ~clr_mask;
      arrived <= 1'b0;
      case (state)
        IDLE: begin
          // A bit left at the current floor (set while passing it) is served in place.
          if (req_here || here_pend) begin
            state     <= DOOR_OPEN;
            door_open <= 1'b1;
            door_tmr  <= '0;
            arrived   <= 1'b1;
          end else if (|pending) begin
            // Keep direction if work remains that way; otherwise reverse.
            is_up    <= up_avail & (is_up | ~dn_avail);
            state    <= MOVING;
            moving   <= 1'b1;
            move_tmr <= '0;
          end
        end
        MOVING: begin
          if (!move_done) begin
            move_tmr <= move_tmr + 1'b1;
          end else begin
            move_tmr <= '0;
            if (!ahead) begin
              state  <= IDLE;
              moving <= 1'b0;
            end else begin
              current_floor <= step_floor;
              if (step_pend) begin
                state     <= DOOR_OPEN;
                moving    <= 1'b0;
                door_open <= 1'b1;
                door_tmr  <= '0;
                arrived   <= 1'b1;
              end
            end
          end
        end
        DOOR_OPEN: begin
          if (req_here) begin
            door_tmr <= '0;
          end else if (door_done) begin
            state     <= IDLE;
            door_open <= 1'b0;
            door_tmr  <= '0;
          end else begin
            door_tmr <= door_tmr + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          moving    <= 1'b0;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_floor_scheduler.sv
// Scoreboard bench for elevator_floor_scheduler with a behavioural car model.
// Driver steps the model per cycle and queues the expected outputs; a monitor
// pops and compares on every falling edge.
module tb_elevator_floor_scheduler;
  localparam int NF = 10;
  localparam int MC = 4;
  localparam int DC = 6;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [3:0]    req_floor;
  logic [3:0]    current_floor;
  logic [3:0]    target_floor;
  logic          is_up;
  logic          moving;
  logic          door_open;
  logic          arrived;
  logic [NF-1:0] pending;

  elevator_floor_scheduler #(
    .NUM_FLOORS (NF),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .current_floor(current_floor),
    .target_floor (target_floor),
    .is_up        (is_up),
    .moving       (moving),
    .door_open    (door_open),
    .arrived      (arrived),
    .pending      (pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cf;
    int            tgt;
    bit            up;
    bit            mv;
    bit            dr;
    bit            ar;
    logic [NF-1:0] pd;
  } snap_t;

  snap_t exp_q[$];
  string err_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    rst_req = 0;
  int    rst_done = 0;
  bit    chk_en = 1'b0;

  // Behavioural car: position, direction, mode, cycles left in the current
  // activity, and the set of floors still owed a stop.
  int m_pos;
  int m_mode;
  int m_left;
  bit m_up;
  bit m_arr;
  bit m_pend[16];

  function automatic int n_above();
    int n = 0;
    for (int f = m_pos + 1; f < NF; f++) if (m_pend[f]) n++;
    return n;
  endfunction

  function automatic int n_below();
    int n = 0;
    for (int f = 0; f < m_pos; f++) if (m_pend[f]) n++;
    return n;
  endfunction

  function automatic int m_target();
    if (m_up) begin
      for (int f = m_pos + 1; f < NF; f++) if (m_pend[f]) return f;
    end else begin
      for (int f = m_pos - 1; f >= 0; f--) if (m_pend[f]) return f;
    end
    return m_pos;
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_mode = M_IDLE; m_left = 0; m_up = 1'b0; m_arr = 1'b0;
    for (int f = 0; f < 16; f++) m_pend[f] = 1'b0;
  endfunction

  function automatic void model_step(input bit rv, input int rf);
    bit v;
    bit do_set;
    int served;
    v = rv && (rf < NF);
    do_set = v;
    served = -1;
    m_arr = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if ((v && rf == m_pos) || m_pend[m_pos]) begin
          m_mode = M_DOOR; m_left = DC; m_arr = 1'b1; served = m_pos;
        end else if (n_above() + n_below() > 0) begin
          m_up = (n_above() > 0) && (m_up || n_below() == 0);
          m_mode = M_MOVE; m_left = MC;
        end
      end
      M_MOVE: begin
        m_left--;
        if (m_left == 0) begin
          if ((m_up ? n_above() : n_below()) == 0) begin
            m_mode = M_IDLE;
          end else begin
            m_pos = m_up ? m_pos + 1 : m_pos - 1;
            m_left = MC;
            if (m_pend[m_pos]) begin
              m_mode = M_DOOR; m_left = DC; m_arr = 1'b1; served = m_pos;
            end
          end
        end
      end
      default: begin
        if (v && rf == m_pos) begin
          m_left = DC; do_set = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
    if (do_set) m_pend[rf] = 1'b1;
    if (served >= 0) m_pend[served] = 1'b0;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.cf = m_pos; s.tgt = m_target(); s.up = m_up;
    s.mv = (m_mode == M_MOVE); s.dr = (m_mode == M_DOOR); s.ar = m_arr;
    for (int f = 0; f < NF; f++) s.pd[f] = m_pend[f];
    return s;
  endfunction

  function automatic bit m_empty();
    for (int f = 0; f < NF; f++) if (m_pend[f]) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: all counting happens here.
  initial begin
    snap_t e;
    forever begin
      @(negedge clock);
      while (err_q.size() > 0) begin
        n_chk++; n_fail++;
        $display("FAIL %s: bound expired, required event not reached", err_q.pop_front());
      end
      if (rst_req != rst_done) begin
        rst_done = rst_req;
        n_chk++;
        if ({current_floor, target_floor, is_up, moving, door_open, arrived, pending} != '0) begin
          n_fail++;
          $display("FAIL async_reset @%0t: got cf=%0d tgt=%0d up=%0b mv=%0b door=%0b arr=%0b pend=%b, required all zero",
                   $time, current_floor, target_floor, is_up, moving, door_open, arrived, pending);
        end
      end else if (chk_en) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got an output cycle, required a queued expectation", $time);
        end else begin
          e = exp_q.pop_front();
          if (current_floor !== 4'(e.cf) || target_floor !== 4'(e.tgt) || is_up !== e.up ||
              moving !== e.mv || door_open !== e.dr || arrived !== e.ar || pending !== e.pd) begin
            n_fail++;
            $display("FAIL cycle_state @%0t: got cf=%0d tgt=%0d up=%0b mv=%0b door=%0b arr=%0b pend=%b, required cf=%0d tgt=%0d up=%0b mv=%0b door=%0b arr=%0b pend=%b",
                     $time, current_floor, target_floor, is_up, moving, door_open, arrived, pending,
                     e.cf, e.tgt, e.up, e.mv, e.dr, e.ar, e.pd);
          end
        end
      end
    end
  end

  task automatic cycle(input bit v, input int f);
    req_valid = v;
    req_floor = 4'(f);
    model_step(v, f);
    exp_q.push_back(snap());
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    req_floor = 4'd0;
    reset = 1'b1;
    rst_req++;
    chk_en = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    exp_q.push_back(snap());
    chk_en = 1'b1;
  endtask

  task automatic settle(input int max_cyc, input string tag);
    int k = 0;
    while (!(m_mode == M_IDLE && m_empty()) && k < max_cyc) begin
      cycle(1'b0, 0);
      k++;
    end
    if (k >= max_cyc) err_q.push_back(tag);
    idle(2);
  endtask

  task automatic wait_move_at(input int pos, input int left, input string tag);
    int k = 0;
    while (!(m_mode == M_MOVE && m_pos == pos && m_left == left) && k < 300) begin
      cycle(1'b0, 0);
      k++;
    end
    if (k >= 300) err_q.push_back(tag);
  endtask

  initial begin
    do_reset();
    idle(4);
    // Out-of-range floors.
    cycle(1'b1, 12);
    cycle(1'b1, 15);
    idle(3);
    // Single trip 0 -> 3.
    cycle(1'b1, 3);
    settle(100, "single_trip");
    // Top and bottom boundaries.
    cycle(1'b1, 9);
    settle(200, "to_top");
    cycle(1'b1, 0);
    settle(200, "to_bottom");
    // SCAN: heading for 8, past 5, then requests 2 and 7.
    cycle(1'b1, 8);
    wait_move_at(6, MC, "scan_past5");
    cycle(1'b1, 2);
    cycle(1'b1, 7);
    settle(300, "scan_order");
    // Same-floor requests at 5.
    cycle(1'b1, 5);
    settle(200, "go_to_5");
    cycle(1'b1, 5);
    idle(4);
    cycle(1'b1, 5);
    settle(100, "door_extend");
    // Request for 6 on the very cycle the car lands on 6.
    cycle(1'b1, 6);
    wait_move_at(5, 1, "arrive_6");
    cycle(1'b1, 6);
    settle(100, "simultaneous");
    // Random traffic including invalid floors.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)));
    end
    settle(500, "random_drain");
    // Asynchronous reset while moving at floor 4.
    cycle(1'b1, 0);
    settle(200, "home");
    cycle(1'b1, 9);
    wait_move_at(4, 2, "mid_move_4");
    do_reset();
    idle(8);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
